// File: rtl/cpu24_isa_pkg.sv
// ----------------------------------------------------------------------------
// cpu24_isa_pkg
// Shared definitions for the 24-bit CPU instruction set: instruction width,
// opcode values, field bit positions, immediate limits and the loader FSM
// state type. Imported by the field packer and the instruction loader.
// ----------------------------------------------------------------------------
package cpu24_isa_pkg;

    localparam int INSTR_WIDTH = 24;

    // Opcodes understood by the control decoder
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LS    = 4'b0010;
    localparam logic [3:0] OP_SS    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_RTYPE = 4'b0110;

    // Field positions (LSB of each field) within the instruction word
    localparam int OPC_LSB   = 20;
    localparam int RS_LSB    = 18;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 14;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;
    localparam int IMM_W     = 16;

    // Immediate must fit a signed 16-bit field
    localparam logic signed [INSTR_WIDTH-1:0] IMM_MIN = -24'sd32768;
    localparam logic signed [INSTR_WIDTH-1:0] IMM_MAX = 24'sd32767;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } loaderState_e;

endpackage

// File: rtl/instr_field_packer.sv
// ----------------------------------------------------------------------------
// instr_field_packer
// Purely combinational: packs a symbolic instruction request into a 24-bit
// instruction word and reports whether the opcode is known and whether the
// immediate fits the 16-bit field.
//
// Ports:
//   opcode, rs, rt, rd, funct, imm : request fields (imm is signed 24-bit)
//   word     : encoded instruction (unused fields are zero)
//   opLegal  : opcode is one of the supported opcodes
//   immOk    : immediate in range, or not used by this format
// ----------------------------------------------------------------------------
module instr_field_packer
    import cpu24_isa_pkg::*;
(
    input  logic [3:0]                    opcode,
    input  logic [1:0]                    rs,
    input  logic [1:0]                    rt,
    input  logic [1:0]                    rd,
    input  logic [3:0]                    funct,
    input  logic signed [INSTR_WIDTH-1:0] imm,
    output logic [INSTR_WIDTH-1:0]        word,
    output logic                          opLegal,
    output logic                          immOk
);

    // Range check on the full 24-bit signed value, not just the low 16 bits
    function automatic logic immInRange(input logic signed [INSTR_WIDTH-1:0] v);
        return (v >= IMM_MIN) && (v <= IMM_MAX);
    endfunction

    always_comb begin
        word    = '0;
        opLegal = 1'b0;
        immOk   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                opLegal                  = 1'b1;
                word[OPC_LSB +: 4]       = opcode;
                word[RS_LSB +: 2]        = rs;
                word[RT_LSB +: 2]        = rt;
                word[RD_LSB +: 2]        = rd;
                word[FUNCT_LSB +: 4]     = funct;
            end
            OP_LS, OP_SS, OP_BEQ, OP_ADDI: begin
                opLegal                  = 1'b1;
                immOk                    = immInRange(imm);
                word[OPC_LSB +: 4]       = opcode;
                word[RS_LSB +: 2]        = rs;
                word[RT_LSB +: 2]        = rt;
                word[IMM_LSB +: IMM_W]   = imm[IMM_W-1:0];
            end
            default: begin
                opLegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts symbolic instruction requests, encodes them into 24-bit words and
// writes them to consecutive instruction-memory addresses through a
// write/acknowledge handshake. Stops at the last address (no wrap).
//
// Ports:
//   Clock, Reset (async, active-low), Clear (sync restart, highest priority)
//   InValid/InReady      : request handshake
//   InOpcode..InImm      : request fields
//   MemWe/MemAddr/MemData: memory write request, held until MemAck
//   MemAck               : memory accepted the write this cycle
//   Count                : words written since reset/Clear
//   Full                 : last address written
//   Err                  : sticky illegal-opcode / immediate-range flag
// ----------------------------------------------------------------------------
module instr_encoder_loader
    import cpu24_isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Clear,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [3:0]                    InOpcode,
    input  logic [1:0]                    InRs,
    input  logic [1:0]                    InRt,
    input  logic [1:0]                    InRd,
    input  logic [3:0]                    InFunct,
    input  logic signed [INSTR_WIDTH-1:0] InImm,
    output logic                          MemWe,
    output logic [ADDR_WIDTH-1:0]         MemAddr,
    output logic [INSTR_WIDTH-1:0]        MemData,
    input  logic                          MemAck,
    output logic [ADDR_WIDTH:0]           Count,
    output logic                          Full,
    output logic                          Err
);

    localparam logic [ADDR_WIDTH-1:0] BASE_PTR  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

    loaderState_e                 state, stateNext;
    logic [ADDR_WIDTH-1:0]        ptr, ptrNext;
    logic [ADDR_WIDTH:0]          count, countNext;
    logic                         err, errNext;
    logic [INSTR_WIDTH-1:0]       memData, memDataNext;

    logic [INSTR_WIDTH-1:0]       packedWord;
    logic                         opLegal;
    logic                         immOk;

    instr_field_packer u_packer (
        .opcode  (InOpcode),
        .rs      (InRs),
        .rt      (InRt),
        .rd      (InRd),
        .funct   (InFunct),
        .imm     (InImm),
        .word    (packedWord),
        .opLegal (opLegal),
        .immOk   (immOk)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            ptr     <= BASE_PTR;
            count   <= '0;
            err     <= 1'b0;
            memData <= '0;
        end else begin
            state   <= stateNext;
            ptr     <= ptrNext;
            count   <= countNext;
            err     <= errNext;
            memData <= memDataNext;
        end
    end

    always_comb begin
        stateNext   = state;
        ptrNext     = ptr;
        countNext   = count;
        errNext     = err;
        memDataNext = memData;
        // Clear overrides everything, including a pending write and a
        // request presented in the same cycle.
        if (Clear) begin
            stateNext = ST_IDLE;
            ptrNext   = BASE_PTR;
            countNext = '0;
            errNext   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (InValid) begin
                        if (opLegal && immOk) begin
                            stateNext   = ST_WRITE;
                            memDataNext = packedWord;
                        end else begin
                            errNext = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (MemAck) begin
                        countNext = count + COUNT_ONE;
                        // The last address ends loading; pointer never wraps
                        if (ptr == LAST_PTR) begin
                            stateNext = ST_FULL;
                        end else begin
                            ptrNext   = ptr + PTR_ONE;
                            stateNext = ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    stateNext = ST_FULL;
                end
                default: begin
                    stateNext = ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the state register so an
    // asynchronous reset drops MemWe immediately.
    assign InReady = (state == ST_IDLE);
    assign MemWe   = (state == ST_WRITE);
    assign Full    = (state == ST_FULL);
    assign MemAddr = ptr;
    assign MemData = memData;
    assign Count   = count;
    assign Err     = err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int AW = 2;
    localparam int SW = 2 * AW + 5;
    localparam int DEPTH = 1 << AW;

    logic               Clock;
    logic               Reset;
    logic               Clear;
    logic               InValid;
    logic               InReady;
    logic [3:0]         InOpcode;
    logic [1:0]         InRs;
    logic [1:0]         InRt;
    logic [1:0]         InRd;
    logic [3:0]         InFunct;
    logic signed [23:0] InImm;
    logic               MemWe;
    logic [AW-1:0]      MemAddr;
    logic [23:0]        MemData;
    logic               MemAck;
    logic [AW:0]        Count;
    logic               Full;
    logic               Err;

    int checks;
    int failures;

    instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Clear    (Clear),
        .InValid  (InValid),
        .InReady  (InReady),
        .InOpcode (InOpcode),
        .InRs     (InRs),
        .InRt     (InRt),
        .InRd     (InRd),
        .InFunct  (InFunct),
        .InImm    (InImm),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemData  (MemData),
        .MemAck   (MemAck),
        .Count    (Count),
        .Full     (Full),
        .Err      (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- reference helpers (arithmetic from the ISA rules) ----
    function automatic logic [23:0] encodeRef(input int op, input int rs, input int rt,
                                              input int rd, input int fn, input int imm);
        int w;
        if (op == 6)
            w = op * 1048576 + rs * 262144 + rt * 65536 + rd * 16384 + fn;
        else
            w = op * 1048576 + rs * 262144 + rt * 65536 + ((imm % 65536) + 65536) % 65536;
        return w[23:0];
    endfunction

    function automatic bit legalRef(input int op, input int imm);
        bit known;
        known = (op == 1) || (op == 2) || (op == 3) || (op == 4) || (op == 6);
        return known && ((op == 6) || (imm >= -32768 && imm <= 32767));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic setReq(input int op, input int rs, input int rt, input int rd,
                          input int fn, input int imm);
        InOpcode = op[3:0];
        InRs     = rs[1:0];
        InRt     = rt[1:0];
        InRd     = rd[1:0];
        InFunct  = fn[3:0];
        InImm    = imm[23:0];
        InValid  = 1'b1;
    endtask

    task automatic clearPulse();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b0; Clear = 1'b0; InValid = 1'b0; MemAck = 1'b0;
        setReq(0, 0, 0, 0, 0, 0);
        InValid = 1'b0;
        #3;
        tick();
        if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%0b exp=1", InReady); end
        checks++;
        if (MemWe !== 1'b0) begin failures++; $display("FAIL reset_memwe got=%0b exp=0", MemWe); end
        checks++;
        if (MemAddr !== 2'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", MemAddr); end
        checks++;
        if (MemData !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=000000", MemData); end
        checks++;
        if ({Count, Full, Err} !== 5'b0) begin
            failures++; $display("FAIL reset_cnt_full_err got=%0d/%0b/%0b exp=0/0/0", Count, Full, Err);
        end
        checks++;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        setReq(1, 1, 2, 0, 0, 5);
        tick();
        InValid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (MemWe !== 1'b1 || MemAddr !== 2'd0 || MemData !== 24'h160005) begin
                failures++;
                $display("FAIL addi_hold cyc=%0d got we=%0b addr=%0d data=%h exp we=1 addr=0 data=160005",
                         c, MemWe, MemAddr, MemData);
            end
            checks++;
            if (InReady !== 1'b0) begin failures++; $display("FAIL addi_ready_busy got=%0b exp=0", InReady); end
            checks++;
            if (c == 1) MemAck = 1'b1;
            tick();
        end
        MemAck = 1'b0;
        if (MemWe !== 1'b0 || Count !== 3'd1 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL addi_done got we=%0b cnt=%0d rdy=%0b exp we=0 cnt=1 rdy=1", MemWe, Count, InReady);
        end
        checks++;
    endtask

    task automatic test_rtype_beq();
        clearPulse();
        setReq(6, 3, 1, 2, 2, 12345);
        tick();
        InValid = 1'b0;
        if (MemWe !== 1'b1 || MemAddr !== 2'd0 || MemData !== 24'h6D8002) begin
            failures++;
            $display("FAIL rtype_word got we=%0b addr=%0d data=%h exp we=1 addr=0 data=6d8002", MemWe, MemAddr, MemData);
        end
        checks++;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        setReq(4, 0, 1, 3, 15, -3);
        tick();
        InValid = 1'b0;
        if (MemWe !== 1'b1 || MemAddr !== 2'd1 || MemData !== 24'h41FFFD) begin
            failures++;
            $display("FAIL beq_word got we=%0b addr=%0d data=%h exp we=1 addr=1 data=41fffd", MemWe, MemAddr, MemData);
        end
        checks++;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        if (Count !== 3'd2) begin failures++; $display("FAIL rtype_beq_count got=%0d exp=2", Count); end
        checks++;
    endtask

    task automatic test_illegal();
        clearPulse();
        setReq(7, 1, 1, 1, 1, 0);
        tick();
        InValid = 1'b0;
        if (Err !== 1'b1 || MemWe !== 1'b0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL bad_opcode got err=%0b we=%0b rdy=%0b exp err=1 we=0 rdy=1", Err, MemWe, InReady);
        end
        checks++;
        clearPulse();
        if (Err !== 1'b0) begin failures++; $display("FAIL clear_err got=%0b exp=0", Err); end
        checks++;
        setReq(1, 0, 0, 0, 0, 32'h0000_8000);
        tick();
        InValid = 1'b0;
        tick();
        if (Err !== 1'b1 || MemWe !== 1'b0 || Count !== 3'd0) begin
            failures++;
            $display("FAIL imm_range got err=%0b we=%0b cnt=%0d exp err=1 we=0 cnt=0", Err, MemWe, Count);
        end
        checks++;
        setReq(2, 2, 3, 0, 0, -32768);
        tick();
        InValid = 1'b0;
        if (MemWe !== 1'b1 || MemAddr !== 2'd0 || MemData !== 24'h2B8000 || Err !== 1'b1) begin
            failures++;
            $display("FAIL ls_after_err got we=%0b addr=%0d data=%h err=%0b exp we=1 addr=0 data=2b8000 err=1",
                     MemWe, MemAddr, MemData, Err);
        end
        checks++;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
    endtask

    task automatic test_full();
        clearPulse();
        for (int i = 0; i < DEPTH; i++) begin
            setReq(1, i, 0, 0, 0, i);
            tick();
            InValid = 1'b0;
            if (MemWe !== 1'b1 || MemAddr !== i[AW-1:0]) begin
                failures++;
                $display("FAIL full_seq_addr got we=%0b addr=%0d exp we=1 addr=%0d", MemWe, MemAddr, i);
            end
            checks++;
            MemAck = 1'b1;
            tick();
            MemAck = 1'b0;
        end
        if (Full !== 1'b1 || Count !== 3'd4 || InReady !== 1'b0) begin
            failures++;
            $display("FAIL full_flag got full=%0b cnt=%0d rdy=%0b exp full=1 cnt=4 rdy=0", Full, Count, InReady);
        end
        checks++;
        setReq(1, 1, 1, 0, 0, 1);
        MemAck = 1'b1;
        repeat (3) tick();
        InValid = 1'b0;
        MemAck = 1'b0;
        if (MemWe !== 1'b0 || Count !== 3'd4 || MemAddr !== 2'd3 || Full !== 1'b1) begin
            failures++;
            $display("FAIL full_ignore got we=%0b cnt=%0d addr=%0d full=%0b exp we=0 cnt=4 addr=3 full=1",
                     MemWe, Count, MemAddr, Full);
        end
        checks++;
        clearPulse();
        if (Full !== 1'b0 || InReady !== 1'b1 || MemAddr !== 2'd0) begin
            failures++;
            $display("FAIL full_clear got full=%0b rdy=%0b addr=%0d exp full=0 rdy=1 addr=0", Full, InReady, MemAddr);
        end
        checks++;
    endtask

    task automatic test_clear_midwrite();
        setReq(3, 1, 1, 0, 0, 100);
        tick();
        InValid = 1'b0;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        setReq(3, 2, 2, 0, 0, 200);
        tick();
        tick();
        if (MemWe !== 1'b1 || MemAddr !== 2'd1) begin
            failures++; $display("FAIL pre_clear got we=%0b addr=%0d exp we=1 addr=1", MemWe, MemAddr);
        end
        checks++;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        InValid = 1'b0;
        if (MemWe !== 1'b0 || Count !== 3'd0 || MemAddr !== 2'd0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL clear_abort got we=%0b cnt=%0d addr=%0d rdy=%0b exp we=0 cnt=0 addr=0 rdy=1",
                     MemWe, Count, MemAddr, InReady);
        end
        checks++;
        setReq(1, 0, 0, 0, 0, 7);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        InValid = 1'b0;
        if (MemWe !== 1'b0) begin failures++; $display("FAIL clear_drops_req got we=%0b exp=0", MemWe); end
        checks++;
        setReq(1, 3, 3, 0, 0, 1);
        tick();
        InValid = 1'b0;
        if (MemWe !== 1'b1 || MemAddr !== 2'd0 || MemData !== 24'h1F0001) begin
            failures++;
            $display("FAIL post_clear_write got we=%0b addr=%0d data=%h exp we=1 addr=0 data=1f0001", MemWe, MemAddr, MemData);
        end
        checks++;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
    endtask

    task automatic test_reset_midwrite();
        setReq(2, 1, 0, 0, 0, -1);
        tick();
        InValid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        if (MemWe !== 1'b0 || MemAddr !== 2'd0 || MemData !== 24'h0 || Count !== 3'd0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got we=%0b addr=%0d data=%h cnt=%0d rdy=%0b exp we=0 addr=0 data=0 cnt=0 rdy=1",
                     MemWe, MemAddr, MemData, Count, InReady);
        end
        checks++;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        tick();
        setReq(4, 2, 1, 0, 0, 16);
        tick();
        InValid = 1'b0;
        if (MemWe !== 1'b1 || MemAddr !== 2'd0 || MemData !== 24'h490010) begin
            failures++;
            $display("FAIL post_reset_write got we=%0b addr=%0d data=%h exp we=1 addr=0 data=490010", MemWe, MemAddr, MemData);
        end
        checks++;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
    endtask

    task automatic test_random();
        bit          mBusy, mFull, mErr;
        int          mPtr, mCount;
        logic [23:0] mData;
        logic [SW-1:0] obs, exp;
        int op, rs, rt, rd, fn, imm, sel;
        bit clr, vld, ack;
        int legalOps[5] = '{1, 2, 3, 4, 6};

        clearPulse();
        mBusy = 0; mFull = 0; mErr = 0; mPtr = 0; mCount = 0; mData = '0;
        for (int n = 0; n < 400; n++) begin
            op  = ($urandom_range(0, 9) < 7) ? legalOps[$urandom_range(0, 4)] : $urandom_range(0, 15);
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            fn  = $urandom_range(0, 15);
            sel = $urandom_range(0, 3);
            case (sel)
                0: imm = $urandom_range(0, 65535) - 32768;
                1: case ($urandom_range(0, 3))
                       0: imm = -32768;
                       1: imm = 32767;
                       2: imm = -32769;
                       default: imm = 32768;
                   endcase
                2: imm = $urandom_range(0, 16777215) - 8388608;
                default: imm = $urandom_range(0, 200) - 100;
            endcase
            clr = ($urandom_range(0, 99) < 3);
            vld = ($urandom_range(0, 9) < 6);
            ack = ($urandom_range(0, 1) == 1);

            setReq(op, rs, rt, rd, fn, imm);
            InValid = vld;
            Clear   = clr;
            MemAck  = ack;

            if (clr) begin
                mBusy = 0; mFull = 0; mErr = 0; mPtr = 0; mCount = 0;
            end else if (mBusy) begin
                if (ack) begin
                    mBusy = 0;
                    mCount++;
                    if (mPtr == DEPTH - 1) mFull = 1;
                    else mPtr++;
                end
            end else if (!mFull && vld) begin
                if (legalRef(op, imm)) begin
                    mBusy = 1;
                    mData = encodeRef(op, rs, rt, rd, fn, imm);
                end else begin
                    mErr = 1;
                end
            end

            tick();
            obs = {InReady, MemWe, MemAddr, Count, Full, Err};
            exp = {!mBusy && !mFull, mBusy, AW'(mPtr), (AW + 1)'(mCount), mFull, mErr};
            if (obs !== exp) begin
                failures++;
                $display("FAIL rand_state n=%0d got rdy/we/addr/cnt/full/err=%b exp=%b", n, obs, exp);
            end
            checks++;
            if (mBusy) begin
                if (MemData !== mData) begin
                    failures++;
                    $display("FAIL rand_data n=%0d got=%h exp=%h", n, MemData, mData);
                end
                checks++;
            end
        end
        InValid = 1'b0;
        Clear   = 1'b0;
        MemAck  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_addi();
        test_rtype_beq();
        test_illegal();
        test_full();
        test_clear_midwrite();
        test_reset_midwrite();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
